// File: rtl/ctrl_reg_pkg.sv
// Shared definitions for the 32-bit control register word and its
// hardware-side consumers (control register block, tx sequencer).
package ctrl_reg_pkg;

    // Control word layout
    localparam int CTRL_W      = 32;
    localparam int SEND_BIT    = 0;
    localparam int CLEAR_BIT   = 1;
    localparam int EXT_LSB     = 2;
    localparam int EXT_W       = 2;
    localparam int TRANSAC_LSB = 4;
    localparam int TRANSAC_W   = 8;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_SEND  = 3'd3,
        SEQ_WB    = 3'd4,
        SEQ_HOLD  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/ctrl_tx_sequencer.sv
// Control-word driven byte sequencer: on send, snapshots count/bank, reads
// that many bytes from the data buffer, streams them to the serial byte
// transmitter and writes status back through the control register WR2C port.
//
// Transmitter handshake: o_tx_valid/o_tx_data are presented in SEND and held
// stable until a clock edge with o_tx_valid & i_tx_ready; that edge is the
// single transfer of the byte. Valid is never withdrawn before acceptance
// (except by rst).
module ctrl_tx_sequencer
    import ctrl_reg_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int BANK_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CTRL_W-1:0]       i_ctrl,
    output logic                    o_mem_rd,
    output logic [BANK_W+CNT_W-1:0] o_mem_addr,
    input  logic [7:0]              i_mem_data,
    output logic                    o_tx_valid,
    output logic [7:0]              o_tx_data,
    input  logic                    i_tx_ready,
    output logic                    o_wr2c,
    output logic                    o_send,
    output logic                    o_clear,
    output logic [TRANSAC_W-1:0]    o_transac,
    output logic                    o_busy,
    output logic                    o_done
);

    seq_state_t        state_q, state_d;
    logic [BANK_W-1:0] ext_q, ext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]  sent_inc;
    logic              abort_q, abort_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic              send_bit;
    logic              clear_bit;
    logic              unused_ctrl;

    assign send_bit    = i_ctrl[SEND_BIT];
    assign clear_bit   = i_ctrl[CLEAR_BIT];
    // Only send/clear/ext/transac are consumed; the rest of the word is ignored.
    assign unused_ctrl = ^i_ctrl;
    assign sent_inc    = sent_q + CNT_W'(1);

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            ext_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            sent_q    <= '0;
            abort_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sent_q    <= sent_d;
            abort_q   <= abort_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state and datapath update; only the clear bit is watched mid-run.
    always_comb begin
        state_d   = state_q;
        ext_d     = ext_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sent_d    = sent_q;
        abort_d   = abort_q;
        tx_data_d = tx_data_q;

        case (state_q)
            SEQ_IDLE: begin
                if (clear_bit) begin
                    // Clear wins over send and reports zero bytes.
                    sent_d  = '0;
                    abort_d = 1'b0;
                    state_d = SEQ_WB;
                end else if (send_bit) begin
                    ext_d   = i_ctrl[EXT_LSB +: BANK_W];
                    cnt_d   = i_ctrl[TRANSAC_LSB +: CNT_W];
                    idx_d   = '0;
                    sent_d  = '0;
                    abort_d = 1'b0;
                    state_d = (i_ctrl[TRANSAC_LSB +: CNT_W] == '0) ? SEQ_WB : SEQ_FETCH;
                end
            end

            SEQ_FETCH: begin
                if (clear_bit) begin
                    abort_d = 1'b1;
                    state_d = SEQ_WB;
                end else begin
                    state_d = SEQ_WAIT;
                end
            end

            SEQ_WAIT: begin
                tx_data_d = i_mem_data;
                if (clear_bit) begin
                    abort_d = 1'b1;
                    state_d = SEQ_WB;
                end else begin
                    state_d = SEQ_SEND;
                end
            end

            SEQ_SEND: begin
                // A presented byte is never withdrawn; abort only takes
                // effect once the transmitter has taken it.
                if (clear_bit) begin
                    abort_d = 1'b1;
                end
                if (i_tx_ready) begin
                    idx_d  = idx_q + CNT_W'(1);
                    sent_d = sent_inc;
                    if ((sent_inc == cnt_q) || abort_q || clear_bit) begin
                        state_d = SEQ_WB;
                    end else begin
                        state_d = SEQ_FETCH;
                    end
                end
            end

            SEQ_WB: begin
                state_d = SEQ_HOLD;
            end

            SEQ_HOLD: begin
                // Wait for the write-back to clear the request bits.
                if (!send_bit && !clear_bit) begin
                    state_d = SEQ_IDLE;
                end
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registers only.
    assign o_mem_rd   = (state_q == SEQ_FETCH);
    assign o_mem_addr = {ext_q, idx_q};
    assign o_tx_valid = (state_q == SEQ_SEND);
    assign o_tx_data  = tx_data_q;
    assign o_wr2c     = (state_q == SEQ_WB);
    assign o_done     = (state_q == SEQ_WB);
    assign o_send     = 1'b0;
    assign o_clear    = 1'b0;
    assign o_transac  = TRANSAC_W'(sent_q);
    assign o_busy     = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_ctrl_tx_sequencer.sv
// Directed bench for ctrl_tx_sequencer with a byte/write-back scoreboard.
module tb_ctrl_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_ctrl = '0;
    logic        o_mem_rd;
    logic [9:0]  o_mem_addr;
    logic [7:0]  i_mem_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;
    logic        o_wr2c;
    logic        o_send;
    logic        o_clear;
    logic [7:0]  o_transac;
    logic        o_busy;
    logic        o_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wb_q[$];
    logic [7:0] mem [0:1023];

    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = '0;

    // clock / reset
    always #5 clk = ~clk;

    ctrl_tx_sequencer #(.CNT_W(8), .BANK_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ctrl     (i_ctrl),
        .o_mem_rd   (o_mem_rd),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (i_mem_data),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_wr2c     (o_wr2c),
        .o_send     (o_send),
        .o_clear    (o_clear),
        .o_transac  (o_transac),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // buffer model: one-cycle read latency
    always @(posedge clk) begin
        if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor: transmitted bytes, held bytes, write-backs
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tx_hold_valid", o_tx_valid, 1);
                check("tx_hold_data", o_tx_data, data_prev);
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) check("tx_unexpected", o_tx_valid, 0);
                else check("tx_byte", o_tx_data, exp_q.pop_front());
            end
            stall_prev = o_tx_valid && !i_tx_ready;
            data_prev  = o_tx_data;
            if (o_wr2c) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", o_wr2c, 0);
                end else begin
                    check("wb_transac", o_transac, wb_q.pop_front());
                    check("wb_send", o_send, 0);
                    check("wb_clear", o_clear, 0);
                    check("wb_done", o_done, 1);
                end
            end
        end
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_rd"}, o_mem_rd, 0);
        check({tag, "_mem_addr"}, o_mem_addr, 0);
        check({tag, "_tx_valid"}, o_tx_valid, 0);
        check({tag, "_tx_data"}, o_tx_data, 0);
        check({tag, "_wr2c"}, o_wr2c, 0);
        check({tag, "_send"}, o_send, 0);
        check({tag, "_clear"}, o_clear, 0);
        check({tag, "_transac"}, o_transac, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
    endtask

    task automatic idle_gap(input string tag);
        tick();
        tick();
        check({tag, "_idle"}, o_busy, 0);
    endtask

    task automatic push_bytes(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[base + i]);
    endtask

    // One run: c_start is sampled at the start edge, c_run is driven during
    // the run, c_end after the write-back. Cycle 1 is the cycle after the
    // start edge. stall_at/clear_at name the byte (0-based) to stall/abort.
    task automatic run(input string tag, input logic [31:0] c_start, input logic [31:0] c_run,
                       input logic [31:0] c_end, input int n_bytes, input int exp_transac,
                       input int exp_lat, input logic [9:0] addr0, input int stall_at,
                       input int stall_len, input int clear_at);
        int cyc = 0;
        int rd  = 0;
        int acc = 0;
        int stall_left = stall_len;
        bit got = 1'b0;
        bit vld_any = 1'b0;
        wb_q.push_back(8'(exp_transac));
        tick();
        i_ctrl     = c_start;
        i_tx_ready = 1'b1;
        tick();
        i_ctrl = c_run;
        for (int k = 0; k < 2000 && !got; k++) begin
            cyc++;
            if (cyc == 1 && n_bytes > 0) begin
                check({tag, "_fetch_rd"}, o_mem_rd, 1);
                check({tag, "_fetch_addr"}, o_mem_addr, addr0);
            end
            if (o_mem_rd) rd++;
            if (o_tx_valid) vld_any = 1'b1;
            if (o_wr2c) begin
                got = 1'b1;
            end else begin
                i_tx_ready = 1'b1;
                if (o_tx_valid && acc == clear_at) i_ctrl = 32'h2;
                if (o_tx_valid && acc == stall_at && stall_left > 0) begin
                    i_tx_ready = 1'b0;
                    stall_left--;
                end
                if (o_tx_valid && i_tx_ready) acc++;
                tick();
            end
        end
        check({tag, "_wb_seen"}, got, 1);
        if (exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_fetches"}, rd, n_bytes);
        check({tag, "_accepted"}, acc, n_bytes);
        check({tag, "_valid_seen"}, vld_any, (n_bytes > 0) ? 1 : 0);
        i_ctrl = c_end;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;
        mem[10'h102] = 8'h33;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // 3 bytes from bank 1, ready high: write-back in cycle 10
        push_bytes(10'h100, 3);
        run("basic", 32'h35, 32'h0, 32'h0, 3, 3, 10, 10'h100, -1, 0, -1);
        idle_gap("basic");

        // same run, byte 2 stalled 4 cycles
        push_bytes(10'h100, 3);
        run("stall", 32'h35, 32'h0, 32'h0, 3, 3, 14, 10'h100, 1, 4, -1);
        idle_gap("stall");

        // count 0: immediate write-back, no reads, no bytes
        run("cnt0", 32'h09, 32'h0, 32'h0, 0, 0, 1, 10'h000, -1, 0, -1);
        idle_gap("cnt0");

        // clear together with send from idle: clear wins
        run("clr_idle", 32'h33, 32'h0, 32'h0, 0, 0, 1, 10'h000, -1, 0, -1);
        idle_gap("clr_idle");

        // count 5, clear while byte 2 stalled: write-back reports 2
        push_bytes(10'h100, 2);
        run("abort", 32'h55, 32'h0, 32'h0, 2, 2, 11, 10'h100, 1, 4, 1);
        idle_gap("abort");

        // count/ext changed mid-run are ignored; send left high holds in HOLD
        push_bytes(10'h200, 4);
        run("snap", 32'h49, 32'h9D, 32'h9D, 4, 4, 13, 10'h200, -1, 0, -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_busy", o_busy, 1);
            check("hold_no_rd", o_mem_rd, 0);
        end
        i_ctrl = 32'h0;
        tick();
        check("hold_release", o_busy, 0);

        // maximum count completes without wrap
        push_bytes(10'h000, 255);
        run("max255", 32'hFF1, 32'h0, 32'h0, 255, 255, 766, 10'h000, -1, 0, -1);
        idle_gap("max255");

        // reset in WAIT of byte 1: everything clears, no write-back follows
        tick();
        i_ctrl = 32'h2D;
        tick();
        i_ctrl = 32'h0;
        check("rstmid_fetch_rd", o_mem_rd, 1);
        check("rstmid_fetch_addr", o_mem_addr, 10'h300);
        tick();
        check("rstmid_wait_busy", o_busy, 1);
        check("rstmid_wait_valid", o_tx_valid, 0);
        rst = 1'b1;
        tick();
        check_zero("rst_mid");
        rst = 1'b0;
        repeat (20) tick();
        check("rstmid_idle", o_busy, 0);

        // final report
        check("exp_q_drained", exp_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
